// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port block RAM.
// An instruction-fetch port (read only) and a data port (read/write) share
// one memory port. Each access takes an issue cycle (IDLE) plus one
// response cycle (RESP). Simultaneous requests are served round-robin.
// Addresses at or beyond DEPTH complete with an error flag and never
// reach the memory.
module bram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  // memory port
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t state;
  logic   last_data;   // 1: data port was granted most recently
  logic   resp_data;   // access in flight belongs to the data port
  logic   resp_read;   // access in flight is a read
  logic   resp_err;    // access in flight was out of range

  logic              grant_any;
  logic              grant_data;
  logic              grant_we;
  logic              grant_err;
  logic              issue;
  logic              in_resp;
  logic [ADDR_W-1:0] grant_addr;

  // Arbitration: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    grant_any  = if_req | d_req;
    grant_data = d_req & (~if_req | ~last_data);
    grant_addr = grant_data ? d_addr : if_addr;
    grant_we   = grant_data & d_we;
    grant_err  = ({1'b0, grant_addr} >= DEPTH_EXT);
    issue      = rst & (state == IDLE) & grant_any;
    in_resp    = rst & (state == RESP);
  end

  // Memory port is driven combinationally in the issue cycle only; an
  // out-of-range grant keeps both enables low so nothing touches the RAM.
  always_comb begin
    mem_rd_en = issue & ~grant_err & ~grant_we;
    mem_wr_en = issue & ~grant_err & grant_we;
    mem_addr  = issue ? grant_addr : '0;
    mem_wdata = (issue & grant_we) ? d_wdata : '0;
  end

  // Response side: ready pulses during RESP for the granted port; read data
  // passes straight through from the RAM's registered output.
  always_comb begin
    if_ready = in_resp & ~resp_data;
    d_ready  = in_resp & resp_data;
    if_err   = if_ready & resp_err;
    d_err    = d_ready & resp_err;
    if_rdata = (if_ready & ~resp_err) ? mem_rdata : '0;
    d_rdata  = (d_ready & resp_read & ~resp_err) ? mem_rdata : '0;
  end

  // FSM: grant and latch the access in IDLE, complete it in RESP.
  // Reset abandons any in-flight access and hands the next tie to data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_data <= 1'b0;
      resp_data <= 1'b0;
      resp_read <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state     <= RESP;
            last_data <= grant_data;
            resp_data <= grant_data;
            resp_read <= ~grant_we;
            resp_err  <= grant_err;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: directed scenarios followed by two
// concurrent randomized port drivers. Expected responses are queued per
// port at issue time from a transaction-level memory model and checked
// by an independent monitor whenever a ready pulse appears.
module tb_bram_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16384;
  localparam int MIDX_W = 14;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Power-up contents of every word that has not been written.
  function automatic logic [31:0] init_word(int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // ---------------- block RAM model (registered read) ----------------
  logic              mem_clr;
  logic [DATA_W-1:0] bram     [DEPTH];
  logic              bram_vld [DEPTH];
  logic [MIDX_W-1:0] midx;
  assign midx = mem_addr[MIDX_W-1:0];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) bram_vld[i] <= 1'b0;
    end else begin
      if (mem_wr_en) begin
        bram[midx]     <= mem_wdata;
        bram_vld[midx] <= 1'b1;
      end
      if (mem_rd_en) mem_rdata <= bram_vld[midx] ? bram[midx] : init_word(int'(midx));
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t              if_q[$];
  exp_t              d_q[$];
  logic [DATA_W-1:0] ref_mem [int];

  function automatic logic [DATA_W-1:0] ref_read(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic void push_fetch(logic [ADDR_W-1:0] a);
    exp_t e;
    e.addr = a;
    e.err  = (int'(a) >= DEPTH);
    e.data = e.err ? '0 : ref_read(int'(a));
    if_q.push_back(e);
  endfunction

  function automatic void push_data(logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] wd);
    exp_t e;
    e.addr = a;
    e.err  = (int'(a) >= DEPTH);
    e.data = (we || e.err) ? '0 : ref_read(int'(a));
    if (we && !e.err) ref_mem[int'(a)] = wd;
    d_q.push_back(e);
  endfunction

  // Monitor: every ready pulse consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (if_ready) begin
      if (if_q.size() == 0) begin
        check("if_unexpected_ready", 1, 0);
      end else begin
        e = if_q.pop_front();
        $display("txn F addr=%h rdata=%h err=%0d", e.addr, if_rdata, if_err);
        check("if_rdata", if_rdata, e.data);
        check("if_err", if_err, e.err);
      end
    end
    if (d_ready) begin
      if (d_q.size() == 0) begin
        check("d_unexpected_ready", 1, 0);
      end else begin
        e = d_q.pop_front();
        $display("txn D addr=%h rdata=%h err=%0d", e.addr, d_rdata, d_err);
        check("d_rdata", d_rdata, e.data);
        check("d_err", d_err, e.err);
      end
    end
    if (if_ready && d_ready) check("both_ready", 1, 0);
    if (mem_rd_en || mem_wr_en) check("mem_addr_in_range", (int'(mem_addr) < DEPTH), 1);
    if (mem_rd_en && mem_wr_en) check("mem_rd_wr_both", 1, 0);
  end

  // ---------------- port drivers ----------------
  task automatic do_fetch(input logic [ADDR_W-1:0] a, input bit chk);
    int  n;
    bit  inr;
    inr = (int'(a) < DEPTH);
    push_fetch(a);
    @(posedge clk); #1;
    if_addr = a;
    if_req  = 1'b1;
    if (chk) begin
      @(negedge clk);
      check("f_issue_rd", mem_rd_en, inr);
      check("f_issue_wr", mem_wr_en, 0);
      if (inr) check("f_issue_addr", mem_addr, a);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_ready && n < 50);
    if (!if_ready) check("f_timeout", if_ready, 1);
    else if (chk) check("f_latency", n, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input bit chk);
    int  n;
    bit  inr;
    inr = (int'(a) < DEPTH);
    push_data(we, a, wd);
    @(posedge clk); #1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    if (chk) begin
      @(negedge clk);
      check("d_issue_rd", mem_rd_en, !we && inr);
      check("d_issue_wr", mem_wr_en, we && inr);
      if (inr) check("d_issue_addr", mem_addr, a);
      if (we && inr) check("d_issue_wdata", mem_wdata, wd);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ready && n < 50);
    if (!d_ready) check("d_timeout", d_ready, 1);
    else if (chk) check("d_latency", n, 1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr(int lo, int hi);
    if ($urandom_range(0, 7) == 0) return ADDR_W'($urandom_range(DEPTH, 65535));
    return ADDR_W'($urandom_range(lo, hi));
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] pat [8];

  initial begin
    rst = 1'b0; mem_clr = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    pat = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    // Reset with both ports requesting: every output must stay 0.
    if_req = 1'b1; if_addr = 16'h0030;
    d_req  = 1'b1; d_addr  = 16'h0101;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
           mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 0);

    // First tie after reset: D, F, D, F with ready every 2 cycles.
    push_data(1'b0, 16'h0101, '0);
    push_fetch(16'h0030);
    push_data(1'b0, 16'h0101, '0);
    push_fetch(16'h0030);
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) check("tie_first_addr", mem_addr, 16'h0101);
      check("tie_ready_pattern", {if_ready, d_ready}, pat[c]);
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;

    // Fetch-only and write-then-read directed accesses.
    do_data(1'b1, 16'h0010, 32'hDEADBEEF, 1'b1);
    do_fetch(16'h0010, 1'b1);
    do_data(1'b1, 16'h0020, 32'h12345678, 1'b1);
    do_data(1'b0, 16'h0020, '0, 1'b1);

    // Out-of-range accesses, including the first illegal word and the top.
    do_data(1'b0, 16'h4000, '0, 1'b1);
    do_data(1'b1, 16'hFFFF, 32'hCAFEF00D, 1'b1);
    do_fetch(16'h4000, 1'b1);
    do_fetch(16'h3FFF, 1'b1);

    // Reset during RESP: the pending access is dropped without a pulse.
    @(posedge clk); #1;
    d_we = 1'b0; d_addr = 16'h0100; if_addr = 16'h0020;
    d_req = 1'b1; if_req = 1'b1;
    @(negedge clk);
    check("mid_issue", mem_rd_en, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs",
          {if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
           mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 0);
    push_data(1'b0, 16'h0100, '0);
    push_fetch(16'h0020);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_reset_data_first", {mem_rd_en, mem_addr}, {1'b1, 16'h0100});
    @(negedge clk);
    check("post_reset_d_ready", d_ready, 1);
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk);
    check("post_reset_f_issue", {if_ready, mem_rd_en}, 2'b01);
    @(negedge clk);
    check("post_reset_f_ready", if_ready, 1);
    @(posedge clk); #1 if_req = 1'b0;

    // Randomized traffic on both ports concurrently. Fetch addresses stay in
    // a region the data port never writes, so fetch results are order-free.
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          do_fetch(rand_addr(0, 255), 1'b0);
        end
      end
      begin
        for (int i = 0; i < 120; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          do_data(1'($urandom_range(0, 1)), rand_addr(256, 511), $urandom, 1'b0);
        end
      end
    join

    repeat (4) @(negedge clk);
    check("if_q_drained", if_q.size(), 0);
    check("d_q_drained", d_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning word-address width of both ports and of the memory port.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all data buses.
REQ-003 SHALL have parameter DEPTH, default 16384, meaning number of implemented memory words; legal addresses are 0..DEPTH-1.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 if_req  input  1  instruction-fetch read request; held high until if_ready.
REQ-007 if_addr  input  ADDR_W  fetch word address; stable while if_req is high.
REQ-008 if_ready  output  1  one-cycle pulse: fetch complete.
REQ-009 if_rdata  output  DATA_W  fetch data; valid only while if_ready is high, else 0.
REQ-010 if_err  output  1  valid with if_ready: address out of range.
REQ-011 d_req  input  1  data-port request; held high until d_ready.
REQ-012 d_we  input  1  data-port write (1) or read (0); stable while d_req is high.
REQ-013 d_addr  input  ADDR_W  data word address; stable while d_req is high.
REQ-014 d_wdata  input  DATA_W  data-port write data.
REQ-015 d_ready  output  1  one-cycle pulse: data access complete.
REQ-016 d_rdata  output  DATA_W  read data; valid only while d_ready is high with a read, else 0.
REQ-017 d_err  output  1  valid with d_ready: address out of range.
REQ-018 mem_rd_en  output  1  memory read enable.
REQ-019 mem_wr_en  output  1  memory write enable.
REQ-020 mem_addr  output  ADDR_W  memory address.
REQ-021 mem_wdata  output  DATA_W  memory write data.
REQ-022 mem_rdata  input  DATA_W  memory registered read data, valid the cycle after mem_rd_en.

Function
REQ-023 SHALL implement a two-state FSM: IDLE (arbitrate and issue) and RESP (complete the issued access).
REQ-024 In IDLE with no request, SHALL stay in IDLE with mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
REQ-025 In IDLE with exactly one request, SHALL grant that requester, drive mem_* from it combinationally in the same cycle, and go to RESP.
REQ-026 In IDLE with both requests, SHALL grant the port not granted last (round-robin); after reset the data port wins the first tie.
REQ-027 SHALL update the last-grant register on every grant, including erroring grants.
REQ-028 Fetch grant SHALL drive mem_rd_en=1; data grant SHALL drive mem_rd_en=!d_we and mem_wr_en=d_we, with mem_wdata=d_wdata on writes.
REQ-029 If the granted address is >= DEPTH, SHALL keep mem_rd_en and mem_wr_en at 0 and still go to RESP, so no memory access occurs.
REQ-030 In RESP, SHALL pulse the granted port's ready for exactly one cycle, drive all mem enables to 0, and return to IDLE.
REQ-031 In RESP, a granted read SHALL present mem_rdata on the rdata output; writes and errored accesses SHALL present rdata 0.
REQ-032 In RESP, SHALL assert err together with ready for an out-of-range access and hold err at 0 otherwise.
REQ-033 SHALL accept no new grant in RESP; fixed latency is issue cycle + 1, giving at most one access per 2 cycles.
REQ-034 A request present in RESP and still high in the following IDLE cycle SHALL be treated as a new transaction.
REQ-035 The ungranted port SHALL see ready=0 and waits with no request lost.
REQ-036 Request deassertion before ready is illegal; the block need not detect it.

Reset
REQ-037 On rst low, SHALL immediately set state=IDLE and last-grant=fetch, so the data port wins the next tie; an in-flight access is abandoned with no ready pulse.
REQ-038 While rst is low, all outputs SHALL be 0.

Verification
REQ-039 Fetch only: if_req=1, if_addr=0x0010, memory word=0xDEADBEEF -> mem_rd_en=1 at cycle 0; if_ready=1, if_rdata=0xDEADBEEF at cycle 1.
REQ-040 Data write then read: write d_addr=0x0020, d_wdata=0x12345678 -> mem_wr_en=1 at cycle 0, d_ready=1 at cycle 1 with d_rdata=0; a following read returns 0x12345678.
REQ-041 Tie after reset: both ports request -> data granted first, fetch second; grants alternate D,F,D,F with ready pulses 2 cycles apart.
REQ-042 Out of range: d_addr=0x4000 (DEPTH=16384) -> no mem enable at cycle 0; d_ready=1 and d_err=1 at cycle 1.
REQ-043 Reset mid-access: rst low during RESP -> no ready pulse, all outputs 0; after release both ports requesting -> data granted first.
